axis_rx_drop_fifo: RTL and testbench
====================================

AXIS_RX_DROP_FIFO -- requirements
Module: axis_rx_drop_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 512, FIFO capacity in 64-bit beats; power of two, 16..4096.
REQ-002 SHALL have parameter CNT_W, default 16, width of the status counters.
REQ-003 SHALL have port Clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port s, AXIS64u.s, ingress beats from the MAC; User=1 on any beat marks the frame bad.
REQ-006 SHALL have port m, AXIS64.m, egress of good frames only, toward the TCP/IP block.
REQ-007 SHALL have port PktCount, output, CNT_W, wrapping count of committed frames.
REQ-008 SHALL have port DropCount, output, CNT_W, saturating count of dropped frames.
REQ-009 SHALL have port Overflow, output, 1, one-cycle pulse when a frame is dropped for lack of space.

Function
REQ-010 SHALL be store-and-forward: no beat of a frame appears on m before that frame's Last beat has been accepted on s and the frame committed.
REQ-011 SHALL hold s.Ready=1 in every cycle while Reset_n=1; ingress is never back-pressured.
REQ-012 SHALL store each beat as {Data, Keep, Last} (73 bits) at wr_ptr; pointers are log2(DEPTH)+1 bits, wrapping naturally.
REQ-013 SHALL keep commit_ptr (frame-start write position) separate from wr_ptr.
REQ-014 SHALL implement write FSM states ACCEPT and DISCARD; reset state ACCEPT.
REQ-015 ACCEPT: on s.Valid, if used words (wr_ptr - rd_ptr) == DEPTH, go to DISCARD with a sticky overflow flag and rewind wr_ptr to commit_ptr; otherwise write the beat.
REQ-016 ACCEPT, Last beat written: commit (commit_ptr <= wr_ptr+1, PktCount +1) only if no beat of the frame had User=1 and final Keep != 8'h00; else rewind wr_ptr to commit_ptr and DropCount +1.
REQ-017 DISCARD: accept and discard beats until Last; on Last, DropCount +1, Overflow pulses for one cycle if the overflow flag is set, clear the flag, return to ACCEPT.
REQ-018 A full condition hit on the Last beat itself SHALL drop the frame with a single DropCount increment and an Overflow pulse, without entering DISCARD.
REQ-019 A single-beat frame (Valid and Last in the same cycle) SHALL be handled per REQ-016.
REQ-020 Read side: m.Valid=1 when rd_ptr != commit_ptr, with an output register plus a one-entry skid so back-to-back transfers sustain one beat per clock.
REQ-021 A frame committed at cycle N SHALL present its first beat on m.Valid at N+2, provided the egress pipeline is empty.
REQ-022 m.Data/Keep/Last SHALL be held stable while m.Valid=1 and m.Ready=0.
REQ-023 Simultaneous read and write in one cycle SHALL be permitted, including when used == DEPTH and a read frees space in that cycle; full is evaluated on registered pointers, so the write is dropped in that case.
REQ-024 DropCount SHALL saturate at all-ones; PktCount SHALL wrap to zero.

Reset
REQ-025 Reset_n=0 SHALL asynchronously clear wr_ptr, commit_ptr, rd_ptr, skid/output valid, FSM state (ACCEPT), the overflow flag, PktCount, DropCount, and Overflow.
REQ-026 Under reset, m.Valid=0 and s.Ready=0; RAM contents are not reset.
REQ-027 Reset asserted mid-frame SHALL lose the partial frame; after release, the next beat is treated as the start of a new frame.

Structure
REQ-028 Shared package tcp_pkg SHALL hold the rx_fifo_entry_t struct {Data[63:0], Keep[7:0], Last}, the wr_state_t enum {ACCEPT, DISCARD}, and the DEPTH default constant.
REQ-029 Storage SHALL be one sub-module, tcp_sdpram: simple dual-port, one write port and one registered read port, width 73, depth DEPTH, no reset.

Verification
REQ-030 Good frame, 3 beats, Keep last = 8'h0F, m.Ready=1 -> 3 beats out from cycle N+2, data and Keep exact, PktCount=1.
REQ-031 Frame with User=1 on beat 2 of 4, followed by a good 1-beat frame -> only the 1-beat frame emerges, DropCount=1, PktCount=1.
REQ-032 DEPTH=16, m.Ready=0, 20-beat frame -> Overflow pulses once at its Last beat, DropCount=1, m.Valid stays 0, wr_ptr == commit_ptr.
REQ-033 DEPTH=16, two 8-beat good frames then a 1-beat frame, m.Ready=0 -> third frame dropped per REQ-018; then m.Ready=1 -> exactly 16 beats out.
REQ-034 Continuous 1-beat frames with random m.Ready -> no loss while the FIFO is not full, 1 beat/clock throughput when Ready=1, output order preserved.
REQ-035 Reset_n pulsed low mid-frame -> m.Valid=0 immediately, counters=0, next good frame passes intact.

Source files
------------

// File: rtl/axis_rx_drop_fifo_pkg.sv
// tcp_pkg: shared types and defaults for the TCP receive path.
package tcp_pkg;

   localparam int RX_FIFO_DEPTH = 512;

   typedef struct packed {
      logic [63:0] Data;
      logic [7:0]  Keep;
      logic        Last;
   } rx_fifo_entry_t;

   typedef enum logic {ACCEPT, DISCARD} wr_state_t;

endpackage

// File: rtl/axis_rx_drop_fifo_if.sv
// AXIS64u / AXIS64: 64-bit AXI-Stream bundles, with and without the User error flag.
interface AXIS64u;
   logic [63:0] Data;
   logic [7:0]  Keep;
   logic        Last;
   logic        User;
   logic        Valid;
   logic        Ready;
   modport s (input Data, Keep, Last, User, Valid, output Ready);
   modport m (output Data, Keep, Last, User, Valid, input Ready);
endinterface

interface AXIS64;
   logic [63:0] Data;
   logic [7:0]  Keep;
   logic        Last;
   logic        Valid;
   logic        Ready;
   modport s (input Data, Keep, Last, Valid, output Ready);
   modport m (output Data, Keep, Last, Valid, input Ready);
endinterface

// File: rtl/axis_rx_drop_fifo_sdpram.sv
// tcp_sdpram: simple dual-port RAM, one write port and one registered read port, no reset.
module tcp_sdpram #(
   parameter int W     = 73,
   parameter int DEPTH = 512,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);
   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/axis_rx_drop_fifo.sv
// axis_rx_drop_fifo: store-and-forward frame FIFO that drops errored, empty or overflowing frames.
module axis_rx_drop_fifo import tcp_pkg::*; #(
   parameter int DEPTH = RX_FIFO_DEPTH,
   parameter int CNT_W = 16
) (
   input  logic             Clk,
   input  logic             Reset_n,
   AXIS64u.s                s,
   AXIS64.m                 m,
   output logic [CNT_W-1:0] PktCount,
   output logic [CNT_W-1:0] DropCount,
   output logic             Overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] FULL = PW'(DEPTH);

   if (DEPTH < 16 || DEPTH > 4096 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of two in 16..4096");
   end

   wr_state_t state, state_n;
   logic [PW-1:0] wr_ptr, wr_ptr_n, commit_ptr, commit_ptr_n, rd_ptr, fetch_ptr;
   logic ovf, ovf_n, bad, bad_n, we, pkt_inc, drop_inc, ovf_pulse, full;
   logic re, pop, rd_pend, out_v, skid_v;
   logic [1:0] occ;
   rx_fifo_entry_t wr_entry, rd_entry, out_q, skid_q;

   assign s.Ready  = Reset_n;
   assign full     = (wr_ptr - rd_ptr) == FULL;
   assign wr_entry = {s.Data, s.Keep, s.Last};

   // rd_ptr only moves on egress handshakes, so prefetched beats still occupy space
   always_comb begin
      state_n      = state;
      wr_ptr_n     = wr_ptr;
      commit_ptr_n = commit_ptr;
      ovf_n        = ovf;
      bad_n        = bad;
      we           = 1'b0;
      pkt_inc      = 1'b0;
      drop_inc     = 1'b0;
      ovf_pulse    = 1'b0;
      if (s.Valid && state == DISCARD) begin
         if (s.Last) begin
            drop_inc  = 1'b1;
            ovf_pulse = ovf;
            ovf_n     = 1'b0;
            state_n   = ACCEPT;
         end
      end else if (s.Valid && full) begin
         wr_ptr_n  = commit_ptr;
         bad_n     = 1'b0;
         drop_inc  = s.Last;
         ovf_pulse = s.Last;
         ovf_n     = !s.Last;
         state_n   = s.Last ? ACCEPT : DISCARD;
      end else if (s.Valid) begin
         we    = 1'b1;
         bad_n = s.Last ? 1'b0 : bad | s.User;
         if (!s.Last) begin
            wr_ptr_n = wr_ptr + PW'(1);
         end else if (!(bad | s.User) && s.Keep != '0) begin
            wr_ptr_n     = wr_ptr + PW'(1);
            commit_ptr_n = wr_ptr + PW'(1);
            pkt_inc      = 1'b1;
         end else begin
            wr_ptr_n = commit_ptr;
            drop_inc = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= ACCEPT;
         wr_ptr     <= '0;
         commit_ptr <= '0;
         ovf        <= 1'b0;
         bad        <= 1'b0;
         PktCount   <= '0;
         DropCount  <= '0;
         Overflow   <= 1'b0;
      end else begin
         state      <= state_n;
         wr_ptr     <= wr_ptr_n;
         commit_ptr <= commit_ptr_n;
         ovf        <= ovf_n;
         bad        <= bad_n;
         PktCount   <= PktCount + CNT_W'(pkt_inc);
         DropCount  <= DropCount + CNT_W'(drop_inc & ~&DropCount);
         Overflow   <= ovf_pulse;
      end
   end

   tcp_sdpram #(.W($bits(rx_fifo_entry_t)), .DEPTH(DEPTH)) ram (
      .clk   (Clk),
      .we    (we),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (wr_entry),
      .re    (re),
      .raddr (fetch_ptr[AW-1:0]),
      .rdata (rd_entry)
   );

   // a read is issued only if its data is guaranteed a free slot in output or skid
   assign pop = out_v & m.Ready;
   assign occ = 2'(out_v) + 2'(skid_v) + 2'(rd_pend);
   assign re  = (fetch_ptr != commit_ptr) && (occ - 2'(pop) <= 2'd1);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rd_ptr    <= '0;
         fetch_ptr <= '0;
         rd_pend   <= 1'b0;
         out_v     <= 1'b0;
         skid_v    <= 1'b0;
         out_q     <= '0;
         skid_q    <= '0;
      end else begin
         rd_ptr    <= rd_ptr + PW'(pop);
         fetch_ptr <= fetch_ptr + PW'(re);
         rd_pend   <= re;
         if (pop) begin
            out_v  <= skid_v | rd_pend;
            out_q  <= skid_v ? skid_q : rd_entry;
            skid_v <= skid_v & rd_pend;
            if (skid_v) skid_q <= rd_entry;
         end else if (rd_pend && out_v) begin
            skid_v <= 1'b1;
            skid_q <= rd_entry;
         end else if (rd_pend) begin
            out_v <= 1'b1;
            out_q <= rd_entry;
         end
      end
   end

   assign m.Valid = out_v;
   assign m.Data  = out_q.Data;
   assign m.Keep  = out_q.Keep;
   assign m.Last  = out_q.Last;
endmodule

// File: tb/tb_axis_rx_drop_fifo.sv
// tb_axis_rx_drop_fifo: randomized scenarios checked against a frame-queue reference model.
module tb_axis_rx_drop_fifo;
   localparam int DEPTH = 16;

   typedef struct {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
   } beat_t;

   logic Clk = 1'b0;
   logic Reset_n = 1'b0;
   logic [3:0] pkt, drop;
   logic ovf;

   AXIS64u s();
   AXIS64  m();

   axis_rx_drop_fifo #(.DEPTH(DEPTH), .CNT_W(4)) dut (
      .Clk       (Clk),
      .Reset_n   (Reset_n),
      .s         (s),
      .m         (m),
      .PktCount  (pkt),
      .DropCount (drop),
      .Overflow  (ovf)
   );

   always #5 Clk = ~Clk;

   beat_t exp_q[$];
   beat_t cur_q[$];
   logic [3:0] pkt_exp, drop_exp;
   logic ovf_exp, bad, discard;
   int checks = 0, errors = 0, cyc = 0, pops = 0, ovf_seen = 0, first_pop = -1, last_pop = -1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
      $fatal(1, "timeout");
   end

   task automatic model_reset();
      exp_q.delete();
      cur_q.delete();
      pkt_exp  = '0;
      drop_exp = '0;
      ovf_exp  = 1'b0;
      bad      = 1'b0;
      discard  = 1'b0;
   endtask

   // one clock: drive inputs, score the egress handshake, apply the frame rules, advance
   task automatic step(input logic v, input logic [63:0] d, input logic [7:0] k,
                       input logic l, input logic u, input logic rdy);
      int stored;
      beat_t b;
      s.Valid = v; s.Data = d; s.Keep = k; s.Last = l; s.User = u; m.Ready = rdy;
      if (ovf === 1'b1) ovf_seen++;
      checks++;
      if (pkt !== pkt_exp || drop !== drop_exp || ovf !== ovf_exp || s.Ready !== 1'b1) begin
         errors++;
         $display("FAIL status at cycle %0d: pkt %0d drop %0d ovf %b ready %b, want pkt %0d drop %0d ovf %b ready 1",
                  cyc, pkt, drop, ovf, s.Ready, pkt_exp, drop_exp, ovf_exp);
      end
      stored = exp_q.size() + cur_q.size();
      ovf_exp = 1'b0;
      if (m.Valid === 1'b1 && rdy) begin
         checks++;
         pops++;
         if (first_pop < 0) first_pop = cyc;
         last_pop = cyc;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL egress at cycle %0d: got beat %h/%h/%b, want no beat", cyc, m.Data, m.Keep, m.Last);
         end else begin
            b = exp_q.pop_front();
            if (m.Data !== b.d || m.Keep !== b.k || m.Last !== b.l) begin
               errors++;
               $display("FAIL egress at cycle %0d: got %h/%h/%b, want %h/%h/%b",
                        cyc, m.Data, m.Keep, m.Last, b.d, b.k, b.l);
            end
         end
      end
      if (v && discard) begin
         if (l) begin
            discard  = 1'b0;
            drop_exp = (drop_exp == 4'hF) ? drop_exp : drop_exp + 1'b1;
            ovf_exp  = 1'b1;
         end
      end else if (v && stored == DEPTH) begin
         cur_q.delete();
         bad = 1'b0;
         if (l) begin
            drop_exp = (drop_exp == 4'hF) ? drop_exp : drop_exp + 1'b1;
            ovf_exp  = 1'b1;
         end else discard = 1'b1;
      end else if (v) begin
         cur_q.push_back('{d, k, l});
         bad = bad | u;
         if (l) begin
            if (!bad && k != 8'h00) begin
               foreach (cur_q[i]) exp_q.push_back(cur_q[i]);
               pkt_exp = pkt_exp + 1'b1;
            end else drop_exp = (drop_exp == 4'hF) ? drop_exp : drop_exp + 1'b1;
            cur_q.delete();
            bad = 1'b0;
         end
      end
      @(posedge Clk);
      cyc++;
      @(negedge Clk);
   endtask

   task automatic send_frame(input int n, input int bad_at, input logic [7:0] lk, input int rdy_pct);
      for (int i = 0; i < n; i++)
         step(1'b1, {$urandom, $urandom}, (i == n - 1) ? lk : 8'hFF, i == n - 1, i == bad_at,
              $urandom_range(99) < rdy_pct);
   endtask

   task automatic idle(input int n, input int rdy_pct);
      for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, $urandom_range(99) < rdy_pct);
   endtask

   task automatic drain(input string name);
      int t = 0;
      while ((exp_q.size() != 0 || m.Valid === 1'b1) && t < 200) begin
         step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
         t++;
      end
      idle(4, 100);
      checks++;
      if (exp_q.size() != 0 || m.Valid !== 1'b0) begin
         errors++;
         $display("FAIL %s drain: %0d beats outstanding, m.Valid %b, want 0 beats and 0", name, exp_q.size(), m.Valid);
      end
   endtask

   task automatic test_reset();
      s.Valid = 1'b0; s.Data = '0; s.Keep = '0; s.Last = 1'b0; s.User = 1'b0; m.Ready = 1'b0;
      Reset_n = 1'b0;
      repeat (3) @(negedge Clk);
      checks++;
      if (m.Valid !== 1'b0) begin errors++; $display("FAIL reset m.Valid: got %b want 0", m.Valid); end
      checks++;
      if (s.Ready !== 1'b0) begin errors++; $display("FAIL reset s.Ready: got %b want 0", s.Ready); end
      checks++;
      if (pkt !== 4'd0 || drop !== 4'd0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset counters: got pkt %0d drop %0d ovf %b want 0 0 0", pkt, drop, ovf);
      end
      model_reset();
      Reset_n = 1'b1;
      #1;
      checks++;
      if (s.Ready !== 1'b1) begin errors++; $display("FAIL release s.Ready: got %b want 1", s.Ready); end
      @(negedge Clk);
   endtask

   task automatic test_good_frame();
      int p0 = pops;
      int e;
      step(1'b1, 64'h0123456789ABCDEF, 8'hFF, 1'b0, 1'b0, 1'b1);
      step(1'b1, 64'hFEDCBA9876543210, 8'hFF, 1'b0, 1'b0, 1'b1);
      step(1'b1, 64'h00000000DEADBEEF, 8'h0F, 1'b1, 1'b0, 1'b1);
      e = cyc;
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (m.Valid !== 1'b0) begin errors++; $display("FAIL good latency N+1: m.Valid %b want 0 (cycle %0d, commit %0d)", m.Valid, cyc, e); end
      step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      checks++;
      if (m.Valid !== 1'b1 || m.Data !== 64'h0123456789ABCDEF) begin
         errors++;
         $display("FAIL good latency N+2: m.Valid %b data %h want 1 0123456789abcdef", m.Valid, m.Data);
      end
      drain("good");
      checks++;
      if (pops - p0 != 3 || pkt !== 4'd1) begin
         errors++;
         $display("FAIL good frame: beats %0d pkt %0d want 3 and 1", pops - p0, pkt);
      end
   endtask

   task automatic test_user_drop();
      int p0 = pops;
      send_frame(4, 1, 8'hFF, 100);
      send_frame(1, -1, 8'h3C, 100);
      drain("user");
      checks++;
      if (pops - p0 != 1 || drop !== 4'd1 || pkt !== 4'd2) begin
         errors++;
         $display("FAIL user drop: beats %0d drop %0d pkt %0d want 1 1 2", pops - p0, drop, pkt);
      end
   endtask

   task automatic test_overflow();
      int p0 = pops;
      int o0 = ovf_seen;
      logic vs = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, {$urandom, $urandom}, 8'hFF, i == 19, 1'b0, 1'b0);
         vs = vs | (m.Valid !== 1'b0);
      end
      for (int i = 0; i < 3; i++) begin
         idle(1, 0);
         vs = vs | (m.Valid !== 1'b0);
      end
      checks++;
      if (vs !== 1'b0) begin errors++; $display("FAIL overflow m.Valid: got %b want 0", vs); end
      checks++;
      if (ovf_seen - o0 != 1 || drop !== 4'd2) begin
         errors++;
         $display("FAIL overflow pulses %0d drop %0d want 1 and 2", ovf_seen - o0, drop);
      end
      send_frame(16, -1, 8'hFF, 0);
      idle(3, 0);
      checks++;
      if (pkt !== 4'd3 || drop !== 4'd2 || m.Valid !== 1'b1) begin
         errors++;
         $display("FAIL refill after overflow: pkt %0d drop %0d valid %b want 3 2 1", pkt, drop, m.Valid);
      end
      drain("refill");
      checks++;
      if (pops - p0 != 16) begin errors++; $display("FAIL refill beats: got %0d want 16", pops - p0); end
   endtask

   task automatic test_full_last();
      int o0 = ovf_seen;
      int p0;
      send_frame(8, -1, 8'hFF, 0);
      send_frame(8, -1, 8'hFF, 0);
      send_frame(1, -1, 8'h01, 0);
      idle(3, 0);
      checks++;
      if (ovf_seen - o0 != 1 || drop !== 4'd3 || pkt !== 4'd5) begin
         errors++;
         $display("FAIL full on last: pulses %0d drop %0d pkt %0d want 1 3 5", ovf_seen - o0, drop, pkt);
      end
      p0 = pops;
      drain("full_last");
      checks++;
      if (pops - p0 != 16) begin errors++; $display("FAIL full on last beats: got %0d want 16", pops - p0); end
   endtask

   task automatic test_back_to_back();
      int p0 = pops;
      first_pop = -1;
      for (int i = 0; i < 24; i++) send_frame(1, -1, 8'hFF, 100);
      drain("b2b");
      checks++;
      if (pops - p0 != 24 || last_pop - first_pop != 23) begin
         errors++;
         $display("FAIL back to back: beats %0d span %0d want 24 and 23", pops - p0, last_pop - first_pop);
      end
      checks++;
      if (pkt !== 4'd13) begin errors++; $display("FAIL pkt wrap: got %0d want 13", pkt); end
   endtask

   task automatic test_random();
      int p0 = pops;
      for (int f = 0; f < 60; f++) begin
         int n;
         n = ($urandom_range(9) == 0) ? int'($urandom_range(20, 10)) : int'($urandom_range(6, 1));
         send_frame(n, ($urandom_range(9) == 0) ? int'($urandom_range(n - 1)) : -1,
                    ($urandom_range(9) == 0) ? 8'h00 : 8'($urandom_range(255, 1)), 60);
         idle($urandom_range(2), 60);
      end
      drain("random");
      checks++;
      if (pops - p0 == 0) begin errors++; $display("FAIL random traffic: got 0 beats want more than 0"); end
   endtask

   task automatic test_reset_mid_frame();
      int p0;
      send_frame(2, -1, 8'hFF, 0);
      idle(3, 0);
      checks++;
      if (m.Valid !== 1'b1) begin errors++; $display("FAIL pre-reset m.Valid: got %b want 1", m.Valid); end
      for (int i = 0; i < 3; i++) step(1'b1, {$urandom, $urandom}, 8'hFF, 1'b0, 1'b0, 1'b0);
      #2;
      Reset_n = 1'b0;
      s.Valid = 1'b0;
      #1;
      checks++;
      if (m.Valid !== 1'b0 || s.Ready !== 1'b0) begin
         errors++;
         $display("FAIL async reset: m.Valid %b s.Ready %b want 0 0", m.Valid, s.Ready);
      end
      checks++;
      if (pkt !== 4'd0 || drop !== 4'd0 || ovf !== 1'b0) begin
         errors++;
         $display("FAIL async reset counters: pkt %0d drop %0d ovf %b want 0 0 0", pkt, drop, ovf);
      end
      model_reset();
      @(negedge Clk);
      Reset_n = 1'b1;
      p0 = pops;
      send_frame(4, -1, 8'h07, 100);
      drain("after_reset");
      checks++;
      if (pops - p0 != 4 || pkt !== 4'd1) begin
         errors++;
         $display("FAIL frame after reset: beats %0d pkt %0d want 4 and 1", pops - p0, pkt);
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_user_drop();
      test_overflow();
      test_full_last();
      test_back_to_back();
      test_random();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
